// File: rtl/fifo_input_control.sv
// ---------------------------------------------------------------------------
// fifo_input_control
//
// Write-side controller for a byte FIFO. It accepts producer writes, drives
// the write port of the FIFO storage, and tracks occupancy using pop pulses
// from the output control stage.
//
// Data value 8'h00 is reserved as the "empty" marker used by the output
// stage. Writes carrying 8'h00 are dropped and flagged on zero_drop.
//
// Every output comes from a flop. The occupancy flags are registered from
// the next-count value, so they always agree with the registered count.
//
// Handshake semantics (single point of reference):
//   write_en : Sampled every rising edge. There is no ready/backpressure
//              signal. A write is accepted when write_en=1, data_in!=0 and
//              the registered count is below DEPTH. A nonzero write at
//              DEPTH is rejected and raises overflow. A zero write is
//              dropped and raises zero_drop.
//   rd_done  : One-cycle pop pulse. It decrements the count only when the
//              registered count is nonzero. A pop at empty is ignored.
//   write_en_o / wr_ptr / wr_data :
//              Registered write strobe. These appear one cycle after the
//              write is accepted. write_en_o is high for exactly one cycle
//              per accepted write.
//
// Optional feature macro: FIFO_IN_OVF_STICKY_EN
//   defined   : overflow is sticky until a cycle with ovf_clr=1. A new
//               overflow in that same cycle wins.
//   undefined : overflow pulses for one cycle per rejected write, and
//               ovf_clr is ignored.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   write_en     in   producer write request
//   data_in      in   [7:0] producer data
//   rd_done      in   pop pulse from the output control stage
//   ovf_clr      in   clear for the sticky overflow flag
//   write_en_o   out  memory write strobe
//   wr_ptr       out  [AW-1:0] memory write address
//   wr_data      out  [7:0] memory write data
//   count        out  [AW:0] occupancy, 0..DEPTH
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL_TH
//   empty        out  count == 0
//   overflow     out  rejected-write flag (pulse, or sticky; see above)
//   zero_drop    out  one-cycle pulse when a zero byte was dropped
//   state_dbg    out  [1:0] occupancy FSM state (S_EMPTY/S_FILL/S_FULL)
// ---------------------------------------------------------------------------
module fifo_input_control #(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int AFULL_TH = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [7:0]    data_in,
  input  logic          rd_done,
  input  logic          ovf_clr,
  output logic          write_en_o,
  output logic [AW-1:0] wr_ptr,
  output logic [7:0]    wr_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic          overflow,
  output logic          zero_drop,
  output logic [1:0]    state_dbg
);

  // Occupancy FSM encoding
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_TH_C = (AW+1)'(AFULL_TH);

  // Registered state
  logic [AW:0]   count_q,       count_d;
  logic [AW-1:0] wr_addr_q,     wr_addr_d;
  logic          write_en_o_q,  write_en_o_d;
  logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [7:0]    wr_data_q,     wr_data_d;
  logic          overflow_q,    overflow_d;
  logic          zero_drop_q,   zero_drop_d;
  logic          full_q,        full_d;
  logic          almost_full_q, almost_full_d;
  logic          empty_q,       empty_d;
  logic [1:0]    state_q,       state_d;

  // Per-cycle decisions, all based on the pre-update count
  logic nonzero_wr;
  logic accept;
  logic reject;
  logic pop;

  always_comb begin
    nonzero_wr = write_en && (data_in != 8'h00);
    // A pop in the same cycle does not free a slot for a write at full.
    // Acceptance looks only at the registered count.
    accept     = nonzero_wr && (count_q != DEPTH_C);
    reject     = nonzero_wr && (count_q == DEPTH_C);
    pop        = rd_done && (count_q != '0);
  end

  // Occupancy and write address
  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;  // idle, or a write and a pop that cancel
    endcase

    // DEPTH is 2**AW, so the natural AW-bit wrap takes DEPTH-1 back to 0
    wr_addr_d = accept ? wr_addr_q + 1'b1 : wr_addr_q;
  end

  // Memory write port, registered (latency 1 from acceptance)
  always_comb begin
    write_en_o_d = accept;
    wr_ptr_d     = accept ? wr_addr_q : wr_ptr_q;
    wr_data_d    = accept ? data_in   : wr_data_q;
  end

  // Error flags
  always_comb begin
    zero_drop_d = write_en && (data_in == 8'h00);
`ifdef FIFO_IN_OVF_STICKY_EN
    // A new event beats a clear in the same cycle
    overflow_d  = reject || (overflow_q && !ovf_clr);
`else
    overflow_d  = reject;
`endif
  end

  // Occupancy FSM and flags follow the next count. The count moves by at
  // most one per cycle, so S_EMPTY and S_FULL are always separated by
  // S_FILL.
  always_comb begin
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == DEPTH_C) begin
      state_d = S_FULL;
    end else begin
      state_d = S_FILL;
    end

    empty_d       = (count_d == '0);
    full_d        = (count_d == DEPTH_C);
    almost_full_d = (count_d >= AFULL_TH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      wr_addr_q     <= '0;
      write_en_o_q  <= 1'b0;
      wr_ptr_q      <= '0;
      wr_data_q     <= 8'h00;
      overflow_q    <= 1'b0;
      zero_drop_q   <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
      state_q       <= S_EMPTY;
    end else begin
      count_q       <= count_d;
      wr_addr_q     <= wr_addr_d;
      write_en_o_q  <= write_en_o_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_data_q     <= wr_data_d;
      overflow_q    <= overflow_d;
      zero_drop_q   <= zero_drop_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      empty_q       <= empty_d;
      state_q       <= state_d;
    end
  end

`ifndef FIFO_IN_OVF_STICKY_EN
  // The clear input has no effect when overflow is a plain pulse
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  assign write_en_o  = write_en_o_q;
  assign wr_ptr      = wr_ptr_q;
  assign wr_data     = wr_data_q;
  assign count       = count_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign empty       = empty_q;
  assign overflow    = overflow_q;
  assign zero_drop   = zero_drop_q;
  assign state_dbg   = state_q;

endmodule
